pipe_decode: RTL and testbench

PIPE_DECODE -- requirements
Module: pipe_decode

---
 rtl/pipe_decode_pkg.sv | 63 ++++++
 rtl/decode_regfile.sv | 32 +++
 rtl/pipe_decode.sv | 115 +++++++++++
 tb/tb_pipe_decode.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_decode_pkg.sv
// Shared definitions for the pipe_decode stage: instruction field layout,
// opcode values and the packed control bundle produced by the decoder.
package pipe_decode_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 11;
  localparam int OP_W    = 5;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 11;
  localparam int SH_LSB  = 11;
  localparam int SH_W    = 2;

  localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OP_W-1:0] OP_FFT  = 5'b01000;
  localparam logic [OP_W-1:0] OP_MEM  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ALU  = 5'b01010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_FREQ = 5'b01100;
  localparam logic [OP_W-1:0] OP_SET  = 5'b01110;
  localparam logic [OP_W-1:0] OP_SYN  = 5'b01111;
  // Immediate-load group is matched on op[4:2] only.
  localparam logic [2:0]      OP_IMM_GRP = 3'b001;

  typedef struct packed {
    logic halt;
    logic alu_op;
    logic reg_wr_en;
    logic mem_wr_en;
    logic branch;
    logic fft_wr_en;
    logic set_en;
    logic syn;
    logic use_imm;
    logic set_freq;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    if (op[4:2] == OP_IMM_GRP) begin
      c.use_imm   = 1'b1;
      c.reg_wr_en = 1'b1;
    end
    case (op)
      OP_HALT: c.halt      = 1'b1;
      OP_FFT:  c.fft_wr_en = 1'b1;
      OP_MEM:  c.mem_wr_en = 1'b1;
      OP_ALU: begin
        c.alu_op    = 1'b1;
        c.reg_wr_en = 1'b1;
      end
      OP_BR:   c.branch    = 1'b1;
      OP_FREQ: c.set_freq  = 1'b1;
      OP_SET:  c.set_en    = 1'b1;
      OP_SYN:  c.syn       = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports, one write port and a
// write-through bypass so a same-cycle write is visible on the read ports.
module decode_regfile #(
  parameter  int NUMREGISTERS = 8,
  parameter  int DATAW        = 32,
  localparam int AW           = $clog2(NUMREGISTERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_reg,
  input  logic [DATAW-1:0] wr_data,
  input  logic [AW-1:0]    rd_a_reg,
  input  logic [AW-1:0]    rd_b_reg,
  output logic [DATAW-1:0] rd_a,
  output logic [DATAW-1:0] rd_b
);

  logic [DATAW-1:0] regs [NUMREGISTERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMREGISTERS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_reg] <= wr_data;
    end
  end

  assign rd_a = (wr_en && wr_reg == rd_a_reg) ? wr_data : regs[rd_a_reg];
  assign rd_b = (wr_en && wr_reg == rd_b_reg) ? wr_data : regs[rd_b_reg];

endmodule

// File: rtl/pipe_decode.sv
// Decode stage: fetch-side handshake, hazard scoreboard, registered decode
// outputs toward execute, and a sticky halt.
module pipe_decode
  import pipe_decode_pkg::*;
#(
  parameter  int NUMREGISTERS = 8,
  parameter  int DATAW        = 32,
  localparam int AW           = $clog2(NUMREGISTERS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      wr_reg,
  input  logic [DATAW-1:0]   wr_data,
  input  logic               reg_wr_en_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATAW-1:0]   a,
  output logic [DATAW-1:0]   b,
  output logic [AW-1:0]      dst_reg,
  output logic [IMM_W-1:0]   imm,
  output logic [SH_W-1:0]    shift_dist,
  output logic               halt,
  output logic               alu_op,
  output logic               reg_wr_en_out,
  output logic               mem_wr_en,
  output logic               branch,
  output logic               fft_wr_en,
  output logic               set_en,
  output logic               syn,
  output logic               use_imm,
  output logic               set_freq,
  output logic               halted
);

  localparam logic [NUMREGISTERS-1:0] ONE = NUMREGISTERS'(1);

  logic [OP_W-1:0]         op;
  logic [AW-1:0]           a_reg, b_reg;
  ctrl_t                   dec, ctrl_q;
  logic [DATAW-1:0]        rd_a, rd_b;
  logic [NUMREGISTERS-1:0] pending, clr_mask, set_mask, live;
  logic                    hazard, accept;

  assign op    = instr[OP_LSB +: OP_W];
  assign a_reg = instr[A_LSB +: AW];
  assign b_reg = instr[B_LSB +: AW];
  assign dec   = decode_op(op);

  decode_regfile #(.NUMREGISTERS(NUMREGISTERS), .DATAW(DATAW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (reg_wr_en_in),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_a_reg (a_reg),
    .rd_b_reg (b_reg),
    .rd_a     (rd_a),
    .rd_b     (rd_b)
  );

  // A bit being written back this cycle no longer blocks; the bypass covers it.
  assign clr_mask = reg_wr_en_in ? (ONE << wr_reg) : '0;
  assign live     = pending & ~clr_mask;
  assign hazard   = in_valid && (op != OP_HALT) && (live[a_reg] || live[b_reg]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !halted;
  assign accept   = in_valid && in_ready;
  assign set_mask = (accept && dec.reg_wr_en) ? (ONE << a_reg) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      halted  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (accept && dec.halt) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      a          <= '0;
      b          <= '0;
      dst_reg    <= '0;
      imm        <= '0;
      shift_dist <= '0;
      ctrl_q     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      a          <= rd_a;
      b          <= rd_b;
      dst_reg    <= a_reg;
      imm        <= instr[IMM_LSB +: IMM_W];
      shift_dist <= instr[SH_LSB +: SH_W];
      ctrl_q     <= dec;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign halt          = ctrl_q.halt;
  assign alu_op        = ctrl_q.alu_op;
  assign reg_wr_en_out = ctrl_q.reg_wr_en;
  assign mem_wr_en     = ctrl_q.mem_wr_en;
  assign branch        = ctrl_q.branch;
  assign fft_wr_en     = ctrl_q.fft_wr_en;
  assign set_en        = ctrl_q.set_en;
  assign syn           = ctrl_q.syn;
  assign use_imm       = ctrl_q.use_imm;
  assign set_freq      = ctrl_q.set_freq;

endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: reset, bypass, hazard/scoreboard,
// backpressure, random decode against a table, and halt with async reset.
module tb_pipe_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        in_valid, in_ready;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic        reg_wr_en_in;
  logic        out_valid, out_ready;
  logic [31:0] a, b;
  logic [2:0]  dst_reg;
  logic [10:0] imm;
  logic [1:0]  shift_dist;
  logic        halt, alu_op, reg_wr_en_out, mem_wr_en, branch, fft_wr_en;
  logic        set_en, syn, use_imm, set_freq, halted;
  logic [9:0]  ctl;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] model [8];

  always #5 clk = ~clk;

  pipe_decode #(.NUMREGISTERS(8), .DATAW(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .wr_reg(wr_reg), .wr_data(wr_data), .reg_wr_en_in(reg_wr_en_in),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .dst_reg(dst_reg), .imm(imm), .shift_dist(shift_dist),
    .halt(halt), .alu_op(alu_op), .reg_wr_en_out(reg_wr_en_out), .mem_wr_en(mem_wr_en),
    .branch(branch), .fft_wr_en(fft_wr_en), .set_en(set_en), .syn(syn),
    .use_imm(use_imm), .set_freq(set_freq), .halted(halted)
  );

  assign ctl = {halt, alu_op, reg_wr_en_out, mem_wr_en, branch, fft_wr_en,
                set_en, syn, use_imm, set_freq};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // [9]halt [8]alu [7]reg_wr [6]mem_wr [5]branch [4]fft [3]set_en [2]syn [1]use_imm [0]set_freq
  function automatic logic [9:0] exp_ctrl(input logic [4:0] op);
    if (op inside {5'b00100, 5'b00101, 5'b00110, 5'b00111}) return 10'b0010000010;
    case (op)
      5'b00000: return 10'b1000000000;
      5'b01000: return 10'b0000010000;
      5'b01001: return 10'b0001000000;
      5'b01010: return 10'b0110000000;
      5'b01011: return 10'b0000100000;
      5'b01100: return 10'b0000000001;
      5'b01110: return 10'b0000001000;
      5'b01111: return 10'b0000000100;
      default:  return 10'b0;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic send(input logic [15:0] ins);
    int w;
    w = 0;
    instr = ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins, ins_x, ins_y;
    logic [31:0] d;
    logic [9:0]  ec;

    rst_n = 1'b0; instr = '0; in_valid = 1'b0; wr_reg = '0; wr_data = '0;
    reg_wr_en_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ctl", ctl, 10'b0);
    @(posedge clk); #1;

    // fresh registers read as zero, result one cycle after acceptance
    for (int i = 0; i < 4; i++) begin
      send({5'b01000, 3'(2*i), 3'(2*i+1), 5'd0});
      chk("rst_rd_valid", out_valid, 1'b1);
      chk("rst_rd_a", a, 32'h0);
      chk("rst_rd_b", b, 32'h0);
      chk("rst_rd_fft", ctl, 10'b0000010000);
    end

    // same-cycle write of r3 is bypassed to a
    wr_reg = 3'd3; wr_data = 32'hDEADBEEF; reg_wr_en_in = 1'b1;
    send({5'b01000, 3'd3, 3'd0, 5'd0});
    reg_wr_en_in = 1'b0;
    chk("byp_a", a, 32'hDEADBEEF);
    chk("byp_b", b, 32'h0);
    send({5'b01000, 3'd5, 3'd3, 5'd0});
    chk("rd_later_b", b, 32'hDEADBEEF);
    chk("rd_later_a", a, 32'h0);

    // hazard on r2 after an immediate load targeting it
    send({5'b00100, 3'd2, 3'd0, 5'd0});
    chk("imm_ctl", ctl, 10'b0010000010);
    chk("imm_dst", dst_reg, 3'd2);
    instr = {5'b01010, 3'd2, 3'd1, 5'd0};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("haz_block", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    wr_reg = 3'd2; wr_data = 32'h12345678; reg_wr_en_in = 1'b1;
    @(negedge clk);
    chk("haz_release", in_ready, 1'b1);
    @(posedge clk); #1;
    reg_wr_en_in = 1'b0;
    chk("haz_a", a, 32'h12345678);
    chk("haz_ctl", ctl, 10'b0110000000);
    chk("haz_dst", dst_reg, 3'd2);
    // the ALU op re-set r2 in the same edge its write-back cleared it
    instr = {5'b01000, 3'd2, 3'd0, 5'd0};
    @(negedge clk);
    chk("set_wins", in_ready, 1'b0);
    @(posedge clk); #1;
    reg_wr_en_in = 1'b1;
    @(negedge clk);
    chk("set_wins_rel", in_ready, 1'b1);
    @(posedge clk); #1;
    reg_wr_en_in = 1'b0; in_valid = 1'b0;
    chk("set_wins_a", a, 32'h12345678);
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 1'b0);

    // backpressure
    out_ready = 1'b0;
    ins_x = {5'b01001, 3'd3, 3'd4, 5'd7};
    ins_y = {5'b01011, 3'd0, 3'd0, 5'h15};
    send(ins_x);
    instr = ins_y;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_a", a, 32'hDEADBEEF);
      chk("bp_ctl", ctl, 10'b0001000000);
      chk("bp_imm", imm, ins_x[10:0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_ctl", ctl, 10'b0000100000);
    chk("bp_next_imm", imm, ins_y[10:0]);

    // random decode with write-back after each register-writing op
    do_reset();
    for (int i = 0; i < 500; i++) begin
      ins = 16'($urandom);
      if (ins[15:11] == 5'b00000) ins[15:11] = 5'b10000;
      ec = exp_ctrl(ins[15:11]);
      send(ins);
      chk("rnd_ctl", ctl, ec);
      chk("rnd_shift", shift_dist, ins[12:11]);
      chk("rnd_imm", imm, ins[10:0]);
      chk("rnd_dst", dst_reg, ins[10:8]);
      chk("rnd_a", a, model[ins[10:8]]);
      chk("rnd_b", b, model[ins[7:5]]);
      if (ec[7]) begin
        d = $urandom;
        wr_reg = ins[10:8]; wr_data = d; reg_wr_en_in = 1'b1;
        @(posedge clk); #1;
        reg_wr_en_in = 1'b0;
        model[ins[10:8]] = d;
      end
    end

    // halt, then async reset while stalled
    send({5'b00000, 3'd1, 3'd0, 5'd0});
    chk("halt_out", halt, 1'b1);
    chk("halted", halted, 1'b1);
    chk("halt_a", a, model[1]);
    out_ready = 1'b0;
    instr = {5'b01000, 3'd0, 3'd0, 5'd0};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_block", in_ready, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ctl", ctl, 10'b0);
    chk("arst_halted", halted, 1'b0);
    chk("arst_dst", dst_reg, 3'd0);
    chk("arst_a", a, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send({5'b01000, 3'd1, 3'd0, 5'd0});
    chk("post_rst_a", a, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
